// File: rtl/read_data_capture_pkg.sv
// Shared constants and types for the SDRAM read-data capture block:
// bus widths, burst-length encoding and the capture FSM states.
package read_data_capture_pkg;

  localparam int DSIZE   = 32;
  localparam int CL_SIZE = 2;

  localparam logic [1:0] BL_1 = 2'd0;
  localparam logic [1:0] BL_2 = 2'd1;
  localparam logic [1:0] BL_4 = 2'd2;
  localparam logic [1:0] BL_8 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_CL = 2'd1,
    ST_BURST   = 2'd2
  } state_t;

  // Beat-counter preload: number of beats in the burst minus one.
  function automatic logic [3:0] beats_minus_one(input logic [1:0] bl);
    case (bl)
      BL_1:    return 4'd0;
      BL_2:    return 4'd1;
      BL_4:    return 4'd3;
      BL_8:    return 4'd7;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/read_data_capture.sv
// Captures SDRAM read bursts: waits out the CAS latency after a reada command,
// then registers one data beat per cycle and flags the last beat of the burst.
module read_data_capture
  import read_data_capture_pkg::*;
#(
  parameter int dsize   = DSIZE,
  parameter int cl_size = CL_SIZE
) (
  input  logic               clk0,
  input  logic               reset_n,
  input  logic               read_cmd,
  input  logic [cl_size-1:0] cas_lat,
  input  logic [1:0]         burst_len,
  input  logic [dsize-1:0]   sdram_dq,
  output logic [dsize-1:0]   rd_data,
  output logic               rd_valid,
  output logic               rd_last,
  output logic               busy,
  output logic               rd_err
);

  localparam logic [cl_size-1:0] LAT_ONE = cl_size'(1);

  state_t             r_state;
  state_t             w_state_next;
  logic [cl_size-1:0] r_lat_cnt;
  logic [3:0]         r_beat_cnt;
  logic               w_accept;
  logic               w_reject;
  logic               w_capture;
  logic               w_last;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_capture    = 1'b0;
    w_last       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (read_cmd) begin
          if (cas_lat != '0) begin
            w_accept     = 1'b1;
            w_state_next = ST_WAIT_CL;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      ST_WAIT_CL: begin
        w_reject = read_cmd;
        // The first beat is sampled on the edge where the latency count expires;
        // a single-beat burst finishes right there without visiting BURST.
        if (r_lat_cnt == LAT_ONE) begin
          w_capture    = 1'b1;
          w_last       = (r_beat_cnt == 4'd0);
          w_state_next = w_last ? ST_IDLE : ST_BURST;
        end
      end
      ST_BURST: begin
        w_reject  = read_cmd;
        w_capture = 1'b1;
        w_last    = (r_beat_cnt == 4'd0);
        if (w_last) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      r_lat_cnt  <= '0;
      r_beat_cnt <= 4'd0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      rd_valid <= w_capture;
      rd_last  <= w_last;
      rd_err   <= w_reject;
      if (w_capture) rd_data <= sdram_dq;
      if (w_accept) begin
        r_lat_cnt  <= cas_lat;
        r_beat_cnt <= beats_minus_one(burst_len);
      end else begin
        if (r_state == ST_WAIT_CL && r_lat_cnt != '0) r_lat_cnt <= r_lat_cnt - LAT_ONE;
        if (w_capture && r_beat_cnt != 4'd0)           r_beat_cnt <= r_beat_cnt - 4'd1;
      end
    end
  end

  // Busy is a pure decode of the state register, so it drops in the same cycle
  // the last beat is presented and a new command can be taken then.
  assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_read_data_capture.sv
// Self-checking bench for read_data_capture: directed scenarios plus random
// command streams, all checked against a cycle-indexed burst timing model.
module tb_read_data_capture;

  localparam int MAXC = 64;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic        busy;
    logic        err;
    logic [31:0] data;
  } out_t;

  logic        clk0 = 1'b0;
  logic        reset_n = 1'b0;
  logic        read_cmd = 1'b0;
  logic [1:0]  cas_lat = 2'd0;
  logic [1:0]  burst_len = 2'd0;
  logic [31:0] sdram_dq = '0;
  logic [31:0] rd_data;
  logic        rd_valid, rd_last, busy, rd_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic        stim_cmd [MAXC];
  logic [1:0]  stim_cas [MAXC];
  logic [1:0]  stim_bl  [MAXC];
  logic [31:0] stim_dq  [MAXC];
  out_t        exp_o    [MAXC];
  out_t        obs_o    [MAXC];

  read_data_capture #(.dsize(32), .cl_size(2)) dut (
    .clk0(clk0), .reset_n(reset_n), .read_cmd(read_cmd), .cas_lat(cas_lat),
    .burst_len(burst_len), .sdram_dq(sdram_dq), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_last(rd_last), .busy(busy), .rd_err(rd_err)
  );

  always #5 clk0 = ~clk0;

  function automatic string fmt_out(input out_t o);
    return $sformatf("v=%b l=%b busy=%b err=%b d=%h", o.valid, o.last, o.busy, o.err, o.data);
  endfunction

  // Idle commands; cas/burst_len wander randomly so that later changes
  // must not disturb an accepted burst.
  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      stim_cmd[c] = 1'b0;
      stim_cas[c] = 2'($urandom_range(0, 3));
      stim_bl[c]  = 2'($urandom_range(0, 3));
      stim_dq[c]  = $urandom;
    end
  endtask

  // Timing model: a command accepted in cycle t with latency L and N beats
  // shows beat k (data sampled in cycle t+L+k) in cycle t+L+1+k, is busy in
  // cycles t+1 .. t+L+N-1 and frees the block at t+L+N. Rejects err at t+1.
  task automatic build_model(input int len);
    int free_at;
    logic [31:0] held;
    free_at = 0;
    for (int c = 0; c < MAXC; c++) exp_o[c] = '0;
    for (int t = 0; t < len; t++) begin
      if (stim_cmd[t]) begin
        if (t < free_at || stim_cas[t] == 2'd0) begin
          if (t + 1 < MAXC) exp_o[t+1].err = 1'b1;
        end else begin
          int lat = int'(stim_cas[t]);
          int n = 1 << stim_bl[t];
          for (int k = 0; k < n; k++) begin
            int cyc = t + lat + 1 + k;
            if (cyc < MAXC) begin
              exp_o[cyc].valid = 1'b1;
              exp_o[cyc].last  = (k == n - 1);
              exp_o[cyc].data  = stim_dq[cyc-1];
            end
          end
          for (int b = t + 1; b < t + lat + n && b < MAXC; b++) exp_o[b].busy = 1'b1;
          free_at = t + lat + n;
        end
      end
    end
    held = '0;
    for (int c = 0; c < MAXC; c++) begin
      if (exp_o[c].valid) held = exp_o[c].data;
      else                exp_o[c].data = held;
    end
  endtask

  // Leaves the bench at #1 after the edge that starts cycle 0, reset released.
  task automatic apply_reset();
    read_cmd = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(posedge clk0);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic run_scenario(input int len);
    build_model(len);
    apply_reset();
    for (int c = 0; c < len; c++) begin
      obs_o[c]  = {rd_valid, rd_last, busy, rd_err, rd_data};
      read_cmd  = stim_cmd[c];
      cas_lat   = stim_cas[c];
      burst_len = stim_bl[c];
      sdram_dq  = stim_dq[c];
      @(posedge clk0);
      #1;
    end
    read_cmd = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({rd_valid, rd_last, busy, rd_err, rd_data} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset: got v=%b l=%b busy=%b err=%b d=%h, want all zero",
               rd_valid, rd_last, busy, rd_err, rd_data);
    end
  endtask

  task automatic test_basic();
    clear_stim();
    stim_cmd[0] = 1'b1; stim_cas[0] = 2'd2; stim_bl[0] = 2'd2;
    for (int k = 0; k < 4; k++) stim_dq[2+k] = 32'hA0A0_0000 + k;
    run_scenario(12);
    for (int c = 0; c < 12; c++) begin
      n_tests++;
      if (obs_o[c] !== exp_o[c]) begin
        n_fail++;
        $display("FAIL basic cyc%0d: got %s want %s", c, fmt_out(obs_o[c]), fmt_out(exp_o[c]));
      end
    end
    n_tests++;
    if (obs_o[3].data !== 32'hA0A0_0000 || obs_o[6].data !== 32'hA0A0_0003 || obs_o[6].last !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ends: got first %h last %h rd_last %b, want a0a00000 a0a00003 1",
               obs_o[3].data, obs_o[6].data, obs_o[6].last);
    end
  endtask

  task automatic test_single();
    clear_stim();
    stim_cmd[0] = 1'b1; stim_cas[0] = 2'd1; stim_bl[0] = 2'd0;
    stim_dq[1] = 32'h1234_5678;
    run_scenario(8);
    for (int c = 0; c < 8; c++) begin
      n_tests++;
      if (obs_o[c] !== exp_o[c]) begin
        n_fail++;
        $display("FAIL single cyc%0d: got %s want %s", c, fmt_out(obs_o[c]), fmt_out(exp_o[c]));
      end
    end
    n_tests++;
    if (obs_o[2] !== {1'b1, 1'b1, 1'b0, 1'b0, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL single_beat: got %s want v=1 l=1 busy=0 err=0 d=12345678", fmt_out(obs_o[2]));
    end
  endtask

  task automatic test_long_reject();
    clear_stim();
    stim_cmd[0] = 1'b1; stim_cas[0] = 2'd3; stim_bl[0] = 2'd3;
    stim_cmd[5] = 1'b1; stim_cas[5] = 2'd1; stim_bl[5] = 2'd0;
    run_scenario(16);
    for (int c = 0; c < 16; c++) begin
      n_tests++;
      if (obs_o[c] !== exp_o[c]) begin
        n_fail++;
        $display("FAIL long cyc%0d: got %s want %s", c, fmt_out(obs_o[c]), fmt_out(exp_o[c]));
      end
    end
    n_tests++;
    if (obs_o[6].err !== 1'b1 || obs_o[4].valid !== 1'b1 || obs_o[11].last !== 1'b1 || obs_o[12].valid !== 1'b0) begin
      n_fail++;
      $display("FAIL long_shape: got err6=%b v4=%b l11=%b v12=%b, want 1 1 1 0",
               obs_o[6].err, obs_o[4].valid, obs_o[11].last, obs_o[12].valid);
    end
  endtask

  task automatic test_back_to_back();
    clear_stim();
    stim_cmd[0] = 1'b1; stim_cas[0] = 2'd2; stim_bl[0] = 2'd1;
    stim_cmd[4] = 1'b1; stim_cas[4] = 2'd2; stim_bl[4] = 2'd1;
    run_scenario(12);
    for (int c = 0; c < 12; c++) begin
      n_tests++;
      if (obs_o[c] !== exp_o[c]) begin
        n_fail++;
        $display("FAIL b2b cyc%0d: got %s want %s", c, fmt_out(obs_o[c]), fmt_out(exp_o[c]));
      end
    end
    n_tests++;
    if (obs_o[4].busy !== 1'b0 || obs_o[5].busy !== 1'b1 || obs_o[8].last !== 1'b1 || obs_o[5].err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_handoff: got busy4=%b busy5=%b l8=%b err5=%b, want 0 1 1 0",
               obs_o[4].busy, obs_o[5].busy, obs_o[8].last, obs_o[5].err);
    end
  endtask

  task automatic test_cas0();
    clear_stim();
    stim_cmd[0] = 1'b1; stim_cas[0] = 2'd0; stim_bl[0] = 2'd3;
    run_scenario(8);
    for (int c = 0; c < 8; c++) begin
      n_tests++;
      if (obs_o[c] !== exp_o[c]) begin
        n_fail++;
        $display("FAIL cas0 cyc%0d: got %s want %s", c, fmt_out(obs_o[c]), fmt_out(exp_o[c]));
      end
    end
    n_tests++;
    if (obs_o[1].err !== 1'b1 || obs_o[2].err !== 1'b0 || obs_o[1].busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cas0_pulse: got err1=%b err2=%b busy1=%b, want 1 0 0",
               obs_o[1].err, obs_o[2].err, obs_o[1].busy);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      clear_stim();
      for (int c = 0; c < MAXC - 14; c++) stim_cmd[c] = ($urandom_range(0, 2) == 0);
      run_scenario(MAXC);
      for (int c = 0; c < MAXC; c++) begin
        n_tests++;
        if (obs_o[c] !== exp_o[c]) begin
          n_fail++;
          $display("FAIL random it%0d cyc%0d: got %s want %s", it, c, fmt_out(obs_o[c]), fmt_out(exp_o[c]));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic seen_valid;
    clear_stim();
    apply_reset();
    read_cmd = 1'b1; cas_lat = 2'd3; burst_len = 2'd3;
    @(posedge clk0);
    #1;
    read_cmd = 1'b0;
    repeat (6) @(posedge clk0);
    #1;
    // Now in cycle 7: fourth beat of the 8-beat burst is on the outputs.
    n_tests++;
    if (rd_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midburst_pre: got v=%b busy=%b, want 1 1", rd_valid, busy);
    end
    @(negedge clk0);
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({rd_valid, rd_last, busy, rd_err, rd_data} !== 36'd0) begin
      n_fail++;
      $display("FAIL midburst_reset: got v=%b l=%b busy=%b err=%b d=%h, want all zero",
               rd_valid, rd_last, busy, rd_err, rd_data);
    end
    @(posedge clk0);
    #1;
    reset_n = 1'b1;
    seen_valid = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk0);
      #1;
      if (rd_valid !== 1'b0 || busy !== 1'b0) seen_valid = 1'b1;
    end
    n_tests++;
    if (seen_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midburst_after: got activity after reset release=%b, want 0", seen_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_long_reject();
    test_back_to_back();
    test_cas0();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
